// File: rtl/sd_port_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sd_port_if                                                      |
// | Purpose  : Block-level requester port into sd_port_arbiter. A requester    |
// |            holds req with a stable op (we/addr/wdata) until it sees ack or |
// |            err.                                                           |
// | Signals  : req    - request, level held                                  |
// |            we     - 1 = write sector, 0 = read sector                      |
// |            addr   - 32-bit sector address                                 |
// |            wdata  - 4096-bit sector write data                            |
// |            ack    - one-cycle completion pulse (arbiter -> requester)     |
// |            err    - sticky fault indication (arbiter -> requester)        |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface sd_port_if;
  logic          req;
  logic          we;
  logic [31:0]   addr;
  logic [4095:0] wdata;
  logic          ack;
  logic          err;

  modport master (output req, we, addr, wdata, input ack, err);
  modport slave  (input req, we, addr, wdata, output ack, err);
endinterface
`default_nettype wire

// File: rtl/sd_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sd_port_arbiter                                                 |
// | Purpose  : Shares one SD card controller between the instruction-side     |
// |            (p0) and data-side (p1) block requesters. Round-robin grant,   |
// |            drives the controller's level-held read/write enables, waits   |
// |            for completion and returns sector data. Any controller error   |
// |            or completion timeout parks the block in a sticky fault.       |
// | Ports    : clk, reset_n            - clock, async active-low reset         |
// |            p0, p1                  - requester ports (sd_port_if.slave)    |
// |            rdata                   - last completed read sector            |
// |            sd_ctrl_addr_read/write - latched sector address                |
// |            sd_ctrl_data_write      - latched write data                    |
// |            sd_ctrl_re/we           - registered controller enables         |
// |            sd_ctrl_data_read       - controller read data                  |
// |            init_*/read_*/write_*   - controller status                     |
// |            ctrl_state              - controller state (1 INIT,2 IDLE,3 ERR)|
// |            grant, busy, fault      - arbiter status                        |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module sd_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          reset_n,
  sd_port_if.slave      p0,
  sd_port_if.slave      p1,
  output logic [4095:0] rdata,
  output logic [31:0]   sd_ctrl_addr_read,
  output logic [31:0]   sd_ctrl_addr_write,
  output logic [4095:0] sd_ctrl_data_write,
  output logic          sd_ctrl_re,
  output logic          sd_ctrl_we,
  input  logic [4095:0] sd_ctrl_data_read,
  input  logic          init_ok,
  input  logic          init_err,
  input  logic          read_ok,
  input  logic          read_err,
  input  logic          write_ok,
  input  logic          write_err,
  input  logic [3:0]    ctrl_state,
  output logic [1:0]    grant,
  output logic          busy,
  output logic          fault
);

  localparam logic [3:0]  CS_IDLE      = 4'd2;
  localparam logic [3:0]  CS_ERROR     = 4'd3;
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT_INIT = 3'd0,
    S_IDLE      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RELEASE   = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t        state, next_state;
  logic          rr, rr_next;          // favoured port when both request
  logic          op_we;                // latched operation of the granted port
  logic [31:0]   addr_q;
  logic [4095:0] wdata_q;
  logic [1:0]    ack, ack_next, grant_next;
  logic          re_next, we_next, busy_next, fault_next;
  logic          latch, capture, win_port, op_ok, op_err;
  logic [23:0]   tmo_cnt;
  logic          tmo_hit;

  assign sd_ctrl_addr_read  = addr_q;
  assign sd_ctrl_addr_write = addr_q;
  assign sd_ctrl_data_write = wdata_q;
  assign p0.ack = ack[0];
  assign p1.ack = ack[1];
  assign p0.err = fault;
  assign p1.err = fault;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_WAIT_INIT;
      rr         <= 1'b0;
      grant      <= 2'b00;
      sd_ctrl_re <= 1'b0;
      sd_ctrl_we <= 1'b0;
      ack        <= 2'b00;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= next_state;
      rr         <= rr_next;
      grant      <= grant_next;
      sd_ctrl_re <= re_next;
      sd_ctrl_we <= we_next;
      ack        <= ack_next;
      busy       <= busy_next;
      fault      <= fault_next;
    end
  end

  always_comb begin
    next_state = state;
    rr_next    = rr;
    grant_next = grant;
    re_next    = sd_ctrl_re;
    we_next    = sd_ctrl_we;
    ack_next   = 2'b00;
    latch      = 1'b0;
    capture    = 1'b0;
    op_ok      = op_we ? write_ok  : read_ok;
    op_err     = op_we ? write_err : read_err;
    // Lone requester wins outright; on contention rr decides.
    win_port   = (p0.req && p1.req) ? rr : p1.req;

    case (state)
      S_WAIT_INIT: begin
        if (init_err || ctrl_state == CS_ERROR)
          next_state = S_FAULT;
        else if (init_ok && ctrl_state == CS_IDLE)
          next_state = S_IDLE;
      end
      S_IDLE: begin
        if (p0.req || p1.req) begin
          latch      = 1'b1;
          grant_next = win_port ? 2'b10 : 2'b01;
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        re_next    = ~op_we;
        we_next    = op_we;
        next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // Error beats ok when both arrive in the same cycle.
        if (op_err || ctrl_state == CS_ERROR || tmo_hit) begin
          next_state = S_FAULT;
        end else if (op_ok) begin
          capture    = ~op_we;
          re_next    = 1'b0;
          we_next    = 1'b0;
          next_state = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (ctrl_state == CS_ERROR) begin
          next_state = S_FAULT;
        end else if (ctrl_state == CS_IDLE && !read_ok && !write_ok) begin
          ack_next   = grant;
          rr_next    = grant[0];       // favour the port that was just served's peer
          grant_next = 2'b00;
          next_state = S_IDLE;
        end
      end
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_FAULT;
    endcase

    if (next_state == S_FAULT) begin
      re_next    = 1'b0;
      we_next    = 1'b0;
      grant_next = 2'b00;
    end
    busy_next  = (next_state != S_IDLE) && (next_state != S_WAIT_INIT) &&
                 (next_state != S_FAULT);
    fault_next = (next_state == S_FAULT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_we   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if (latch) begin
        op_we   <= win_port ? p1.we    : p0.we;
        addr_q  <= win_port ? p1.addr  : p0.addr;
        wdata_q <= win_port ? p1.wdata : p0.wdata;
      end
      if (capture)
        rdata <= sd_ctrl_data_read;
    end
  end

  // The terminal-count compare is registered so the wide compare stays off the
  // state path; the extra stage is why the fault lands TIMEOUT_CYCLES+1 cycles
  // after WAIT_DONE is entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= 24'd0;
      tmo_hit <= 1'b0;
    end else if (state == S_ISSUE) begin
      tmo_cnt <= 24'd0;
      tmo_hit <= 1'b0;
    end else if (state == S_WAIT_DONE) begin
      tmo_cnt <= tmo_cnt + 24'd1;
      tmo_hit <= (tmo_cnt == TIMEOUT_LAST);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sd_port_arbiter                                              |
// | Purpose  : Self-checking bench for sd_port_arbiter. The bench plays both   |
// |            requesters and the SD controller; a small model tracks the     |
// |            favoured port, each port's pending op and the last read data.  |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sd_port_arbiter;
  localparam int unsigned TO = 100;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [4095:0] rdata, sd_ctrl_data_write, sd_ctrl_data_read;
  logic [31:0]   sd_ctrl_addr_read, sd_ctrl_addr_write;
  logic          sd_ctrl_re, sd_ctrl_we;
  logic          init_ok, init_err, read_ok, read_err, write_ok, write_err;
  logic [3:0]    ctrl_state;
  logic [1:0]    grant;
  logic          busy, fault;

  sd_port_if p0_if();
  sd_port_if p1_if();

  sd_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .p0(p0_if), .p1(p1_if), .rdata(rdata),
    .sd_ctrl_addr_read(sd_ctrl_addr_read), .sd_ctrl_addr_write(sd_ctrl_addr_write),
    .sd_ctrl_data_write(sd_ctrl_data_write), .sd_ctrl_re(sd_ctrl_re),
    .sd_ctrl_we(sd_ctrl_we), .sd_ctrl_data_read(sd_ctrl_data_read),
    .init_ok(init_ok), .init_err(init_err), .read_ok(read_ok), .read_err(read_err),
    .write_ok(write_ok), .write_err(write_err), .ctrl_state(ctrl_state),
    .grant(grant), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int            fav;                  // port favoured on contention
  logic [4095:0] last_rd;              // last completed read sector
  logic          pend_we   [2];
  logic [31:0]   pend_addr [2];
  logic [4095:0] pend_wd   [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [4095:0] obs, input logic [4095:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed[63:0]=%0h expected[63:0]=%0h (4096-bit compare)",
             tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [4095:0] rnd_wide();
    logic [4095:0] v;
    for (int i = 0; i < 128; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_req(input int port, input logic we, input logic [31:0] a,
                         input logic [4095:0] wd);
    pend_we[port] = we; pend_addr[port] = a; pend_wd[port] = wd;
    if (port == 0) begin
      p0_if.req = 1'b1; p0_if.we = we; p0_if.addr = a; p0_if.wdata = wd;
    end else begin
      p1_if.req = 1'b1; p1_if.we = we; p1_if.addr = a; p1_if.wdata = wd;
    end
  endtask

  task automatic drop_req(input int port, input bit scramble);
    if (port == 0) begin
      p0_if.req = 1'b0;
      if (scramble) begin p0_if.we = ~p0_if.we; p0_if.addr = ~p0_if.addr; p0_if.wdata = ~p0_if.wdata; end
    end else begin
      p1_if.req = 1'b0;
      if (scramble) begin p1_if.we = ~p1_if.we; p1_if.addr = ~p1_if.addr; p1_if.wdata = ~p1_if.wdata; end
    end
  endtask

  task automatic do_init(input int n);
    bit bad;
    bad = 1'b0;
    ctrl_state = 4'd1; init_ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (busy || grant != 2'b00 || sd_ctrl_re || sd_ctrl_we) bad = 1'b1;
    end
    init_ok = 1'b1; ctrl_state = 4'd2;
    tick();
    init_ok = 1'b0;
    chk("init_quiet", bad, 0);
    chk("idle_busy", busy, 0);
    chk("idle_grant", grant, 0);
  endtask

  // One complete transaction from the current requests. The model picks the
  // winner from the round-robin rule and predicts every visible output.
  task automatic txn(input bit drop_early, input logic [4095:0] rd_data,
                     input int ok_wait, input int rel_wait, output int winner);
    int            w;
    logic [1:0]    g;
    logic          op;
    logic [31:0]   a;
    logic [4095:0] wd;
    w  = (p0_if.req && p1_if.req) ? fav : (p1_if.req ? 1 : 0);
    op = pend_we[w]; a = pend_addr[w]; wd = pend_wd[w];
    g  = (w == 1) ? 2'b10 : 2'b01;
    tick();
    chk("grant", grant, g);
    chk("ack_single", {p1_if.ack, p0_if.ack}, 0);
    chk("addr_rd", sd_ctrl_addr_read, a);
    chk("addr_wr", sd_ctrl_addr_write, a);
    chk("en_before_issue", {sd_ctrl_re, sd_ctrl_we}, 0);
    chk("busy", busy, 1);
    if (drop_early) drop_req(w, 1'b1);
    ctrl_state = 4'd4;
    tick();
    chk("re", sd_ctrl_re, !op);
    chk("we", sd_ctrl_we, op);
    if (op) chkw("wdata", sd_ctrl_data_write, wd);
    for (int i = 0; i < ok_wait; i++) begin
      tick();
      chk("en_hold", {sd_ctrl_re, sd_ctrl_we}, {!op, op});
    end
    if (op) write_ok = 1'b1;
    else begin read_ok = 1'b1; sd_ctrl_data_read = rd_data; end
    tick();
    chk("en_after_ok", {sd_ctrl_re, sd_ctrl_we}, 0);
    if (!op) last_rd = rd_data;
    chkw("rdata", rdata, last_rd);
    for (int i = 0; i < rel_wait; i++) begin
      tick();
      chk("no_early_ack", {p1_if.ack, p0_if.ack}, 0);
    end
    read_ok = 1'b0; write_ok = 1'b0; ctrl_state = 4'd2;
    sd_ctrl_data_read = rnd_wide();
    tick();
    chk("ack", {p1_if.ack, p0_if.ack}, g);
    chk("grant_cleared", grant, 0);
    chk("idle_not_busy", busy, 0);
    chkw("rdata_hold", rdata, last_rd);
    fav = 1 - w;
    drop_req(w, 1'b0);
    winner = w;
  endtask

  int  wseq [4];
  int  wtmp;
  int  n;
  bit  bad;

  initial begin
    reset_n = 1'b0;
    p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = '0; p0_if.wdata = '0;
    p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = '0; p1_if.wdata = '0;
    init_ok = 1'b0; init_err = 1'b0; read_ok = 1'b0; read_err = 1'b0;
    write_ok = 1'b0; write_err = 1'b0; ctrl_state = 4'd1;
    sd_ctrl_data_read = '0;
    fav = 0; last_rd = '0;
    for (int p = 0; p < 2; p++) begin pend_we[p] = 1'b0; pend_addr[p] = '0; pend_wd[p] = '0; end

    // Reset state
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_en", {sd_ctrl_re, sd_ctrl_we}, 0);
    chk("rst_ack", {p1_if.ack, p0_if.ack}, 0);
    chk("rst_err", {p1_if.err, p0_if.err}, 0);
    chk("rst_addr", sd_ctrl_addr_read, 0);
    chkw("rst_rdata", rdata, '0);
    chkw("rst_wdata", sd_ctrl_data_write, '0);
    reset_n = 1'b1;

    // Init: 50 cycles of controller INIT, then IDLE
    do_init(50);

    // Port 0 directed read of sector 0x10
    set_req(0, 1'b0, 32'h0000_0010, '0);
    txn(1'b0, {128{32'hA5A5_A5A5}}, 2, 1, wtmp);

    // Reset mid-transaction: enables drop without waiting for a clock edge
    set_req(1, 1'b0, $urandom, '0);
    tick(); tick();
    chk("mid_re_high", sd_ctrl_re, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_re_drop", sd_ctrl_re, 0);
    chk("async_grant_drop", grant, 0);
    drop_req(1, 1'b0);
    fav = 0; last_rd = '0;
    tick();
    chkw("async_rdata_clr", rdata, '0);
    reset_n = 1'b1;
    do_init(3);

    // Contention: alternation 0,1,0,1 from a fresh reset
    set_req(0, 1'b0, $urandom, '0);
    set_req(1, 1'b0, $urandom, '0);
    txn(1'b0, rnd_wide(), 1, 0, wseq[0]);
    set_req(0, 1'b0, $urandom, '0);
    txn(1'b0, rnd_wide(), 0, 0, wseq[1]);
    set_req(1, 1'b0, $urandom, '0);
    txn(1'b0, rnd_wide(), 3, 2, wseq[2]);
    txn(1'b0, rnd_wide(), 0, 1, wseq[3]);
    chk("alternation", {wseq[0][1:0], wseq[1][1:0], wseq[2][1:0], wseq[3][1:0]}, 8'b00_01_00_01);

    // Randomised traffic
    for (int i = 0; i < 12; i++) begin
      if (!p0_if.req && $urandom_range(0, 1) == 1)
        set_req(0, $urandom_range(0, 1) == 1, $urandom, rnd_wide());
      if (!p1_if.req && ($urandom_range(0, 1) == 1 || !p0_if.req))
        set_req(1, $urandom_range(0, 1) == 1, $urandom, rnd_wide());
      txn($urandom_range(0, 1) == 1, rnd_wide(), $urandom_range(0, 4),
          $urandom_range(0, 2), wtmp);
    end
    for (int k = 0; k < 2; k++)
      if (p0_if.req || p1_if.req) txn(1'b0, rnd_wide(), 1, 1, wtmp);

    // Port 1 directed write; requester drops req right after grant
    set_req(1, 1'b1, 32'h0000_0200, {256{16'h1234}});
    txn(1'b1, rnd_wide(), 2, 1, wtmp);

    // Error: write_ok and write_err together -> fault
    set_req(0, 1'b1, $urandom, rnd_wide());
    tick();
    chk("err_grant", grant, 2'b01);
    ctrl_state = 4'd4;
    tick();
    chk("err_we", sd_ctrl_we, 1);
    write_ok = 1'b1; write_err = 1'b1;
    tick();
    chk("err_fault", fault, 1);
    chk("err_p_errs", {p1_if.err, p0_if.err}, 2'b11);
    chk("err_en_low", {sd_ctrl_re, sd_ctrl_we}, 0);
    chk("err_no_ack", {p1_if.ack, p0_if.ack}, 0);
    chk("err_grant_clr", grant, 0);
    write_ok = 1'b0; write_err = 1'b0; ctrl_state = 4'd2;
    drop_req(0, 1'b0);
    set_req(1, 1'b0, $urandom, '0);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (grant != 2'b00 || sd_ctrl_re || sd_ctrl_we || !fault || busy) bad = 1'b1;
    end
    chk("fault_sticky", bad, 0);
    reset_n = 1'b0;
    #1;
    chk("fault_clr_rst", fault, 0);
    fav = 0; last_rd = '0;
    tick();
    reset_n = 1'b1;
    do_init(3);
    txn(1'b0, rnd_wide(), 0, 0, wtmp);
    chk("post_fault_port", wtmp, 1);

    // Timeout: read that never completes
    set_req(0, 1'b0, $urandom, '0);
    tick();
    ctrl_state = 4'd4;
    tick();
    chk("tmo_re", sd_ctrl_re, 1);
    n = 0;
    for (int i = 1; i <= 2 * TO; i++) begin
      tick();
      if (fault) begin n = i; break; end
    end
    chk("tmo_cycles", n, TO + 1);
    chk("tmo_re_low", sd_ctrl_re, 0);
    chk("tmo_errs", {p1_if.err, p0_if.err}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
